// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - CU64 handshake and mask-write bundle for interrupt_controller
//
// Purpose: groups the control-unit side signals of the interrupt controller.
// Ports (signals):
//   int_ack   CU64 -> ctrl  acknowledge pulse
//   iret      CU64 -> ctrl  return-from-interrupt pulse
//   mask_wr   CU64 -> ctrl  mask load strobe
//   mask_din  CU64 -> ctrl  new mask value (bit=1 disables source)
//   intr      ctrl -> CU64  interrupt request
//   int_id    ctrl -> CU64  index of requested/serviced source
//   int_vect  ctrl -> CU64  service vector address
//   busy      ctrl -> CU64  handshake in progress
interface interrupt_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
);
  logic               int_ack;
  logic               iret;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_din;
  logic               intr;
  logic [ID_W-1:0]    int_id;
  logic [31:0]        int_vect;
  logic               busy;

  modport master (
    output int_ack, iret, mask_wr, mask_din,
    input  intr, int_id, int_vect, busy
  );

  modport slave (
    input  int_ack, iret, mask_wr, mask_din,
    output intr, int_id, int_vect, busy
  );
endinterface

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered priority interrupt controller for CU64
//
// Purpose: latches rising edges on irq_in, applies a mask, picks the lowest
// eligible index and runs the intr / int_ack / iret handshake, one interrupt
// in service at a time.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   irq_in   raw source lines (rising edge = event)
//   pending  latched-event register, for observation
//   bus      handshake/mask bundle (slave side)
module interrupt_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0300,
  parameter int          ID_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           irq_in,
  output logic [NUM_SRC-1:0]           pending,
  interrupt_controller_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    int_id_q;
  logic [ID_W-1:0]    sel;
  logic               any_elig;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pend & ~mask;
  assign any_elig = |eligible;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  // Acknowledge retires the in-flight source's event.
  always_comb begin
    clr = '0;
    if (state == REQ && bus.int_ack) clr[int_id_q] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_elig)    state_n = REQ;
      REQ:     if (bus.int_ack) state_n = SVC;
      SVC:     if (bus.iret)    state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pend     <= '0;
      mask     <= '0;
      int_id_q <= '0;
    end else begin
      irq_prev <= irq_in;
      // A new edge on the source being acked survives the clear.
      pend     <= (pend & ~clr) | rise;
      if (bus.mask_wr) mask <= bus.mask_din;
      // Arbitration sees the mask as it was before this edge.
      if (state == IDLE && any_elig) int_id_q <= sel;
    end
  end

  assign bus.intr     = (state == REQ);
  assign bus.busy     = (state != IDLE);
  assign bus.int_id   = int_id_q;
  assign bus.int_vect = VEC_BASE + (32'(int_id_q) << 2);
  assign pending      = pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;
  localparam int NUM_SRC = 4;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] pending;

  interrupt_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

  interrupt_controller #(.NUM_SRC(NUM_SRC), .VEC_BASE(32'h0000_0300)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .pending (pending),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which source is being requested, which is in service, and the
  // set of latched events; outputs follow directly from those.
  logic [NUM_SRC-1:0] m_pend, m_prev, m_mask, m_rise;
  int                 req_src, svc_src, m_id;
  bit                 found;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend  = '0;
      m_prev  = '0;
      m_mask  = '0;
      req_src = -1;
      svc_src = -1;
      m_id    = 0;
    end else begin
      m_rise = irq_in & ~m_prev;
      m_prev = irq_in;
      if (req_src >= 0) begin
        if (bus.int_ack) begin
          m_pend[req_src] = 1'b0;
          svc_src = req_src;
          req_src = -1;
        end
      end else if (svc_src >= 0) begin
        if (bus.iret) svc_src = -1;
      end else begin
        found = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!found && m_pend[i] && !m_mask[i]) begin
            found   = 1;
            req_src = i;
            m_id    = i;
          end
        end
      end
      m_pend = m_pend | m_rise;
      if (bus.mask_wr) m_mask = bus.mask_din;
    end
  end

  always @(negedge clk) begin
    chk("cyc_intr",    32'(bus.intr),   32'(req_src >= 0));
    chk("cyc_busy",    32'(bus.busy),   32'(req_src >= 0 || svc_src >= 0));
    chk("cyc_int_id",  32'(bus.int_id), 32'(m_id));
    chk("cyc_vect",    bus.int_vect,    32'h0000_0300 + 32'(4 * m_id));
    chk("cyc_pending", 32'(pending),    32'(m_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
  endtask

  task automatic ret();
    bus.iret = 1'b1; tick(); bus.iret = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    irq_in       = '0;
    bus.int_ack  = 1'b0;
    bus.iret     = 1'b0;
    bus.mask_wr  = 1'b0;
    bus.mask_din = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_intr",    32'(bus.intr), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_vect",    bus.int_vect,  32'h0000_0300);
    chk("rst_pending", 32'(pending),  32'd0);

    // single source 2
    irq_in = 4'b0100; tick(); irq_in = '0;
    chk("s2_pend",  32'(pending),  32'h4);
    chk("s2_intr0", 32'(bus.intr), 32'd0);
    tick();
    chk("s2_intr",  32'(bus.intr),   32'd1);
    chk("s2_id",    32'(bus.int_id), 32'd2);
    chk("s2_vect",  bus.int_vect,    32'h0000_0308);
    ack();
    chk("s2_ack_intr", 32'(bus.intr),   32'd0);
    chk("s2_ack_pend", 32'(pending[2]), 32'd0);
    chk("s2_ack_busy", 32'(bus.busy),   32'd1);
    ret();
    chk("s2_ret_busy", 32'(bus.busy), 32'd0);

    // priority 1 over 3
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    chk("pri_vect1", bus.int_vect, 32'h0000_0304);
    ack(); tick(); ret();
    chk("pri_idle", 32'(bus.intr), 32'd0);
    tick();
    chk("pri_intr3", 32'(bus.intr), 32'd1);
    chk("pri_vect3", bus.int_vect,  32'h0000_030C);
    ack(); ret(); tick();

    // masking holds the event
    bus.mask_din = 4'b0001; bus.mask_wr = 1'b1; tick(); bus.mask_wr = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = '0; tick(); tick();
    chk("msk_pend", 32'(pending[0]), 32'd1);
    chk("msk_intr", 32'(bus.intr),   32'd0);
    bus.mask_din = 4'b0000; bus.mask_wr = 1'b1; tick(); bus.mask_wr = 1'b0;
    chk("msk_old", 32'(bus.intr), 32'd0);
    tick();
    chk("msk_intr1", 32'(bus.intr),   32'd1);
    chk("msk_id",    32'(bus.int_id), 32'd0);
    ack(); ret(); tick();

    // new edge during ack: set wins
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    chk("sw_intr", 32'(bus.intr), 32'd1);
    irq_in = 4'b0100; bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0; irq_in = '0;
    chk("sw_pend", 32'(pending[2]), 32'd1);
    chk("sw_svc",  32'(bus.intr),   32'd0);
    ret();
    chk("sw_idle", 32'(bus.intr), 32'd0);
    tick();
    chk("sw_again", 32'(bus.intr),   32'd1);
    chk("sw_id",    32'(bus.int_id), 32'd2);
    ack(); ret(); tick();

    // ignored int_ack in IDLE and iret in REQ
    ack();
    chk("ign_ack", 32'(bus.busy), 32'd0);
    irq_in = 4'b0001; tick(); irq_in = '0; tick();
    ret();
    chk("ign_iret", 32'(bus.intr), 32'd1);
    ack(); ret(); tick();

    // reset mid-REQ with pending 1010, irq_in[1] held across release
    irq_in = 4'b1000; tick(); irq_in = '0; tick();
    irq_in = 4'b0010; tick();
    chk("mr_pend", 32'(pending),  32'hA);
    chk("mr_intr", 32'(bus.intr), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_async_intr", 32'(bus.intr), 32'd0);
    chk("mr_async_pend", 32'(pending),  32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_edge_pend", 32'(pending),  32'h2);
    chk("mr_edge_intr", 32'(bus.intr), 32'd0);
    tick();
    chk("mr_intr1", 32'(bus.intr),   32'd1);
    chk("mr_id1",   32'(bus.int_id), 32'd1);
    irq_in = '0;
    ack(); ret(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Edge-triggered, priority-arbitrated interrupt controller between the IO block's interrupt sources and control unit CU64. It latches rising edges on up to NUM_SRC request lines, applies a software mask, selects the highest-priority pending source, and runs the intr / int_ack / iret handshake with CU64. While that handshake runs, it presents a fixed service vector. Nested interrupts are not supported: one interrupt is in service at a time.

## Interface
- NUM_SRC, 4: number of interrupt sources, 2..16; index 0 is highest priority.
- VEC_BASE, 32'h0000_0300: byte address of the source-0 vector.
- ID_W, $clog2(NUM_SRC): width of int_id.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- irq_in  in  NUM_SRC  raw source lines, synchronous to clk; the rising edge is the event.
- mask_wr  in  1  one-cycle strobe that loads mask_din into the mask register.
- mask_din  in  NUM_SRC  new mask value; bit=1 disables that source.
- int_ack  in  1  CU64 acknowledge; one-cycle pulse.
- iret  in  1  CU64 return-from-interrupt; one-cycle pulse.
- intr  out  1  interrupt request to CU64.
- int_id  out  ID_W  index of the source being requested or serviced.
- int_vect  out  32  VEC_BASE + 4*int_id, computed modulo 2^32.
- busy  out  1  high in state REQ or SVC.
- pending  out  NUM_SRC  latched-event register, for observation.

## Operation
- Edge detect: irq_prev <= irq_in every cycle. A rise is irq_in & ~irq_prev; each rise sets the matching pending bit.
- Mask register: written on mask_wr. Masking a source does not clear its pending bit; the event is held until the source is unmasked.
- eligible = pending & ~mask. The selected source is the lowest set index of eligible.
- FSM states:
  - IDLE: if eligible != 0, latch the selected index into int_id and go to REQ. Otherwise stay in IDLE.
  - REQ: intr=1. On int_ack, clear pending[int_id], drop intr, and go to SVC. A mask change during REQ does not withdraw the request.
  - SVC: intr=0; wait for iret, then go to IDLE. Pending events keep accumulating during SVC.
- Ignored inputs: int_ack outside REQ; iret outside SVC.
- Same-cycle set and clear of one pending bit (a new edge on the source being acked): set wins, so the new event stays pending.
- Same-cycle mask_wr and IDLE arbitration: arbitration uses the old mask value.
- Outputs after reset: state=IDLE, intr=0, int_id=0, int_vect=VEC_BASE, busy=0, pending=0. Internally, mask=0 (all sources enabled) and irq_prev=0.
- Because irq_prev resets to 0, a line already high when reset is released counts as an edge on the first clock.
- Reset asserted mid-handshake: intr drops immediately (asynchronously) and all pending events are lost.

## Timing
- Request latency: rise sampled at edge N sets pending at N; intr is high after edge N+1. That is 2 cycles from sample to intr.
- Acknowledge: int_ack sampled at edge M drops intr after edge M; pending[int_id] is clear after edge M.
- int_id and int_vect are stable from entry into REQ until exit from SVC.
- Return to service: after iret at edge K, the FSM is in IDLE after K. The next intr can be high after edge K+1.
- Minimum spacing between back-to-back interrupts is therefore 1 idle cycle after iret.
- intr, busy, int_id and int_vect are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then a single rise on irq_in[2] -> intr=1 two cycles later, int_id=2, int_vect=32'h0308. Pulse int_ack -> intr=0 next cycle, pending[2]=0. Pulse iret -> busy=0.
- Simultaneous rises on irq_in[3] and irq_in[1] -> source 1 is serviced first (int_vect=32'h0304). After its iret, source 3 is requested (int_vect=32'h030C).
- mask_din=4'b0001 loaded, then a rise on irq_in[0] -> pending[0]=1 and intr stays 0. Load mask 0 -> intr=1 two cycles later with int_id=0.
- New rise on irq_in[2] in the same cycle as int_ack for source 2 -> pending[2] stays 1. The source is requested again one cycle after iret.
- int_ack pulsed in IDLE and iret pulsed in REQ -> no state change, intr unaffected.
- Reset asserted while in REQ with pending=4'b1010 -> intr=0 immediately and pending=0. With irq_in[1] held high across reset release, intr=1 two cycles after the first clock edge.
